// File: rtl/sc_config_shadow_regs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sc_config_shadow_regs                                         |
// | Brief    : Avalon-MM register file with vsync-committed shadow config,   |
// |            sticky status change flags and maskable interrupt.            |
// |            Macro SC_CONFIG_READBACK_EN makes shadow config readable.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sc_config_shadow_regs #(
  parameter int NUM_STATUS = 4,
  parameter int NUM_CONFIG = 13,
  parameter int ADDR_W     = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [31:0]             avalon_s_writedata,
  output logic [31:0]             avalon_s_readdata,
  input  logic [ADDR_W-1:0]       avalon_s_address,
  input  logic [3:0]              avalon_s_byteenable,
  input  logic                    avalon_s_write,
  input  logic                    avalon_s_read,
  input  logic                    avalon_s_chipselect,
  output logic                    avalon_s_waitrequest_n,
  input  logic [32*NUM_STATUS-1:0] status_i,
  input  logic                    vsync_i,
  output logic [32*NUM_CONFIG-1:0] config_o,
  output logic                    commit_pulse_o,
  output logic                    irq_o
);

  localparam int          c_ADDR_CTRL = NUM_STATUS;
  localparam int          c_ADDR_CHG  = NUM_STATUS + 1;
  localparam int          c_ADDR_MASK = NUM_STATUS + 2;
  localparam int          c_ADDR_CFG  = NUM_STATUS + 3;
  localparam logic [31:0] c_BAD_ADDR  = 32'hBAD0C0DE;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } rd_state_e;

  rd_state_e               rd_state_q, rd_state_d;
  logic [31:0]             rdata_q;
  logic [32*NUM_STATUS-1:0] status_q;
  logic                    vsync_q;
  logic                    pending_q, pending_d;
  logic [NUM_STATUS-1:0]   chg_q, chg_d;
  logic [NUM_STATUS-1:0]   mask_q, mask_d;
  logic [31:0]             shadow_q [NUM_CONFIG];
  logic [31:0]             shadow_d [NUM_CONFIG];
  logic [31:0]             active_q [NUM_CONFIG];
  logic                    commit_pulse_q;
  logic                    irq_q;

  logic                    w_wr;
  logic                    w_wr_ctrl;
  logic                    w_wr_chg;
  logic                    w_wr_mask;
  logic                    w_vsync_rise;
  logic                    w_commit;
  logic                    w_rd_capture;
  logic [31:0]             w_rd_mux;
  logic [NUM_STATUS-1:0]   w_chg_set;

  assign w_wr      = avalon_s_chipselect & avalon_s_write;
  assign w_wr_ctrl = w_wr && (avalon_s_address == ADDR_W'(c_ADDR_CTRL));
  assign w_wr_chg  = w_wr && (avalon_s_address == ADDR_W'(c_ADDR_CHG));
  assign w_wr_mask = w_wr && (avalon_s_address == ADDR_W'(c_ADDR_MASK));

  assign w_vsync_rise = vsync_i & ~vsync_q;
  assign w_commit     = (w_vsync_rise & pending_q) | (w_wr_ctrl & avalon_s_writedata[1]);

  // A CTRL arm request in the commit cycle re-arms for the following frame.
  always_comb begin
    pending_d = pending_q;
    if (w_commit) begin
      pending_d = 1'b0;
    end
    if (w_wr_ctrl && avalon_s_writedata[0]) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    w_chg_set = '0;
    for (int k = 0; k < NUM_STATUS; k++) begin
      w_chg_set[k] = (status_i[32*k +: 32] != status_q[32*k +: 32]);
    end
  end

  // Fresh changes override a simultaneous write-1-to-clear.
  assign chg_d = (chg_q & ~(w_wr_chg ? avalon_s_writedata[NUM_STATUS-1:0] : '0)) | w_chg_set;

  always_comb begin
    mask_d = mask_q;
    if (w_wr_mask) begin
      for (int i = 0; i < NUM_STATUS; i++) begin
        if (avalon_s_byteenable[i/8]) begin
          mask_d[i] = avalon_s_writedata[i];
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_CONFIG; j++) begin
      shadow_d[j] = shadow_q[j];
      if (w_wr && (avalon_s_address == ADDR_W'(c_ADDR_CFG + j))) begin
        for (int b = 0; b < 4; b++) begin
          if (avalon_s_byteenable[b]) begin
            shadow_d[j][8*b +: 8] = avalon_s_writedata[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    w_rd_mux = c_BAD_ADDR;
    for (int k = 0; k < NUM_STATUS; k++) begin
      if (avalon_s_address == ADDR_W'(k)) begin
        w_rd_mux = status_i[32*k +: 32];
      end
    end
    if (avalon_s_address == ADDR_W'(c_ADDR_CTRL)) begin
      w_rd_mux = {23'd0, pending_q, 8'd0};
    end
    if (avalon_s_address == ADDR_W'(c_ADDR_CHG)) begin
      w_rd_mux = {{(32-NUM_STATUS){1'b0}}, chg_q};
    end
    if (avalon_s_address == ADDR_W'(c_ADDR_MASK)) begin
      w_rd_mux = {{(32-NUM_STATUS){1'b0}}, mask_q};
    end
    for (int j = 0; j < NUM_CONFIG; j++) begin
      if (avalon_s_address == ADDR_W'(c_ADDR_CFG + j)) begin
`ifdef SC_CONFIG_READBACK_EN
        w_rd_mux = shadow_q[j];
`else
        w_rd_mux = 32'd0;
`endif
      end
    end
  end

  always_comb begin
    rd_state_d   = rd_state_q;
    w_rd_capture = 1'b0;
    case (rd_state_q)
      ST_IDLE: begin
        if (avalon_s_chipselect && avalon_s_read) begin
          w_rd_capture = 1'b1;
          rd_state_d   = ST_RESP;
        end
      end
      ST_RESP: rd_state_d = ST_IDLE;
      default: rd_state_d = ST_IDLE;
    endcase
  end

  // Reset gates the stall combinationally so a read cut off by reset releases the bus at once.
  assign avalon_s_waitrequest_n = ~(w_rd_capture & rst_n_i);
  assign avalon_s_readdata      = (rd_state_q == ST_RESP) ? rdata_q : 32'd0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_state_q     <= ST_IDLE;
      rdata_q        <= 32'd0;
      status_q       <= '0;
      vsync_q        <= 1'b0;
      pending_q      <= 1'b0;
      chg_q          <= '0;
      mask_q         <= '0;
      commit_pulse_q <= 1'b0;
      irq_q          <= 1'b0;
      for (int j = 0; j < NUM_CONFIG; j++) begin
        shadow_q[j] <= 32'd0;
        active_q[j] <= 32'd0;
      end
    end else begin
      rd_state_q     <= rd_state_d;
      if (w_rd_capture) begin
        rdata_q <= w_rd_mux;
      end
      status_q       <= status_i;
      vsync_q        <= vsync_i;
      pending_q      <= pending_d;
      chg_q          <= chg_d;
      mask_q         <= mask_d;
      commit_pulse_q <= w_commit;
      irq_q          <= |(chg_q & mask_q);
      for (int j = 0; j < NUM_CONFIG; j++) begin
        shadow_q[j] <= shadow_d[j];
        if (w_commit) begin
          active_q[j] <= shadow_q[j];
        end
      end
    end
  end

  generate
    for (genvar j = 0; j < NUM_CONFIG; j++) begin : g_cfg_out
      assign config_o[32*j +: 32] = active_q[j];
    end
  endgenerate

  assign commit_pulse_o = commit_pulse_q;
  assign irq_o          = irq_q;

endmodule
`default_nettype wire
